// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU front-end definitions: widths, PC step, reset PC and the fetch entry record.
package instr_fetch_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;

  // One buffered fetch: the instruction word and the address of its successor.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
// Flush wins over push and pop. A pop on a full FIFO frees the slot for a same-cycle push.
module instr_fetch_queue_fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_mem [DEPTH];

  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_d;

  // Qualify requests: nothing moves on a flush, pops need data, pushes need space.
  always_comb begin
    w_do_pop  = i_pop & (r_count != '0) & ~i_flush;
    w_do_push = i_push & ~i_flush & ((r_count != FULL_CNT) | w_do_pop);
  end

  // Occupancy next state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_d = r_count;
    unique case ({w_do_push, w_do_pop})
      2'b10:   w_count_d = r_count + CNT_W'(1);
      2'b01:   w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_d;
    end
  end

  // Entry storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Head entry and status.
  always_comb begin
    o_data  = r_mem[r_rd_ptr];
    o_count = r_count;
    o_full  = (r_count == FULL_CNT);
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the PC, addresses instruction memory and buffers fetched
// words with their PC+4 for decode. A redirect flushes the queue and reloads the PC.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0]  id_pc4_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc4;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  fetch_entry_t      w_wr_entry;
  fetch_entry_t      w_head;

  // Handshake and push control; redirect suppresses both and the FIFO flush drops the head.
  always_comb begin
    w_pc4      = r_pc + PC_STEP;
    w_pop      = id_valid_o & id_ready_i;
    w_push     = ~redirect_i & (~w_full | w_pop);
    w_wr_entry = '{instr: imem_instr_i, pc4: w_pc4};
  end

  // PC register: redirect target has priority, otherwise advance only when a word is taken.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= align_pc(redirect_pc_i);
    end else if (w_push) begin
      r_pc <= w_pc4;
    end
  end

  instr_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop & ~redirect_i),
    .i_flush (redirect_i),
    .i_data  (w_wr_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Decode-side outputs are forced to zero whenever the queue is empty.
  always_comb begin
    imem_addr_o = r_pc;
    id_valid_o  = (w_count != '0);
    id_instr_o  = id_valid_o ? w_head.instr : NOP_INSTR;
    id_pc4_o    = id_valid_o ? w_head.pc4 : '0;
  end

endmodule
